// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and a
// constant clog2 used to size the bit counter.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin), LSB first, one bit per clock,
// with a start/busy/done handshake and registered results.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int             CW   = clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] sa_q, sb_q;
    logic [WIDTH-1:1] sr_q;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;
    logic             a_msb_q, b_msb_q;
    logic             busy_q, done_q, bout_q, ovf_q;
    logic [WIDTH-1:0] d_q;

    logic             dbit, nb;
    logic [WIDTH-1:0] sr_d;
    logic             ovf_d;

    full_subtractor u_cell (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (borrow_q),
        .d    (dbit),
        .bout (nb)
    );

    // sr_q keeps only the upper bits: the newest bit enters at the top and the
    // final result is the last partial shift plus the current cell output.
    assign sr_d  = {dbit, sr_q};
    assign ovf_d = (a_msb_q != b_msb_q) && (dbit != a_msb_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sa_q     <= a;
                        sb_q     <= b;
                        borrow_q <= bin;
                        cnt_q    <= '0;
                        a_msb_q  <= a[WIDTH-1];
                        b_msb_q  <= b[WIDTH-1];
                        busy_q   <= 1'b1;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    borrow_q <= nb;
                    sr_q     <= sr_d[WIDTH-1:1];
                    sa_q     <= sa_q >> 1;
                    sb_q     <= sb_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        d_q     <= sr_d;
                        bout_q  <= nb;
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: the driver queues expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         bin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    wire          busy, done, bout, ovf;
    wire  [W-1:0] d;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    bit   cont_mode = 1'b0;
    int   last_done = -1;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] diff;
        exp_t       r;
        diff   = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
        r.d    = diff[W-1:0];
        r.bout = diff[W];
        r.ovf  = (x[W-1] != y[W-1]) && (diff[W-1] != x[W-1]);
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation (t=%0t)", $time);
            end else begin
                mon_e = sbq.pop_front();
                chk("d", {24'd0, d}, {24'd0, mon_e.d});
                chk("bout", {31'd0, bout}, {31'd0, mon_e.bout});
                chk("ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
            end
            if (cont_mode) begin
                if (last_done >= 0) chk("done_spacing", cyc - last_done, W + 2);
                last_done = cyc;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy=1 expected 0 within 50 cycles");
        end
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input exp_t e);
        wait_idle();
        a     = x;
        b     = y;
        bin   = c;
        start = 1'b1;
        sbq.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    logic [W-1:0] va[8] = '{8'h03, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h00};
    logic [W-1:0] vb[8] = '{8'h05, 8'h01, 8'hFF, 8'h00, 8'hFF, 8'h7F, 8'h80, 8'h01};
    logic         vc[8] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
    exp_t         ve[8] = '{
        '{8'hFE, 1'b1, 1'b0},
        '{8'h7F, 1'b0, 1'b1},
        '{8'h80, 1'b1, 1'b1},
        '{8'hFF, 1'b1, 1'b0},
        '{8'h00, 1'b0, 1'b0},
        '{8'h00, 1'b0, 1'b1},
        '{8'hFE, 1'b1, 1'b1},
        '{8'hFF, 1'b1, 1'b0}
    };

    initial begin
        logic [W-1:0] prev_d;
        int           n;
        int           guard;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_d", {24'd0, d}, 0);
        chk("rst_bout", {31'd0, bout}, 0);
        chk("rst_ovf", {31'd0, ovf}, 0);
        rst_n = 1'b1;

        // Latency and handshake timing on 5 - 3
        issue(8'h05, 8'h03, 1'b0, '{8'h02, 1'b0, 1'b0});
        for (int k = 0; k <= W + 1; k++) begin
            @(negedge clk);
            chk($sformatf("done_lat_e%0d", k), {31'd0, done}, (k == W) ? 32'd1 : 32'd0);
            chk($sformatf("busy_lat_e%0d", k), {31'd0, busy}, (k <= W) ? 32'd1 : 32'd0);
        end

        // Directed corner vectors
        for (int i = 0; i < 8; i++) issue(va[i], vb[i], vc[i], ve[i]);
        wait_idle();

        // Start pulse during RUN is ignored; d holds previous result until done
        prev_d = d;
        issue(8'h10, 8'h01, 1'b0, '{8'h0F, 1'b0, 1'b0});
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            chk($sformatf("d_hold_e%0d", k), {24'd0, d}, {24'd0, prev_d});
            if (k == 2) begin
                a     = 8'h55;
                b     = 8'h11;
                bin   = 1'b1;
                start = 1'b1;
            end else if (k == 3) begin
                start = 1'b0;
            end
        end
        wait_idle();
        repeat (12) @(negedge clk);

        // Abort by asynchronous reset mid-operation
        issue(8'h80, 8'h01, 1'b0, '{8'h7F, 1'b0, 1'b1});
        wait_idle();
        issue(8'h33, 8'h11, 1'b0, '{8'h22, 1'b0, 1'b0});
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_d", {24'd0, d}, 0);
        chk("abort_bout", {31'd0, bout}, 0);
        chk("abort_ovf", {31'd0, ovf}, 0);
        sbq.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 0);
        end
        rst_n = 1'b1;
        issue(8'h0A, 8'h0A, 1'b0, '{8'h00, 1'b0, 1'b0});
        wait_idle();

        // Back-to-back operation with start held high
        cont_mode = 1'b1;
        last_done = -1;
        n         = 0;
        guard     = 0;
        while (n < 1000 && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (!busy) begin
                a     = W'($urandom);
                b     = W'($urandom);
                bin   = 1'($urandom_range(0, 1));
                sbq.push_back(model(a, b, bin));
                start = 1'b1;
                n++;
            end
        end
        @(posedge clk);
        #1 start = 1'b0;
        chk("cont_issued", n, 1000);
        wait_idle();
        repeat (3) @(negedge clk);
        cont_mode = 1'b0;
        chk("queue_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
